// File: rtl/sw_fsm_pkg.sv
// Shared types for the switch-driven nibble source: FSM state codes and
// event-pair decode values ({ev1, ev0}).
package sw_fsm_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // Event pair is packed as {ev1 (backward), ev0 (forward)}
    localparam logic [1:0] EV_NONE = 2'b00;
    localparam logic [1:0] EV_FWD  = 2'b01;
    localparam logic [1:0] EV_BWD  = 2'b10;
    localparam logic [1:0] EV_CLR  = 2'b11;

endpackage

// File: rtl/switch_debounce.sv
// One raw switch: 2-flop synchroniser, stable-count debouncer and a registered
// single-cycle rising-edge event.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic ev_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_dly_q;
    logic             ev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle agreeing with the accepted level restarts the stability count
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntMax) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            cnt_q     <= '0;
            deb_dly_q <= 1'b0;
            ev_q      <= 1'b0;
        end else begin
            sync1_q   <= sw_i;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            deb_dly_q <= deb_q;
            ev_q      <= deb_q & ~deb_dly_q;
        end
    end

    assign ev_o = ev_q;

endmodule

// File: rtl/sw_fsm_nibble.sv
// Switch-stepped nibble source for the hex display: forward/backward presses
// walk a 4-state FSM plus a 2-bit wrap counter, i.e. a mod-16 up/down counter.
module sw_fsm_nibble
    import sw_fsm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic       sw1,
    output logic [3:0] nibble,
    output logic [1:0] state,
    output logic       step_pulse
);

    logic       ev0, ev1;
    logic [1:0] ev_pair;
    state_t     state_q, state_d;
    logic [1:0] wrap_q, wrap_d;
    logic       pulse_q, pulse_d;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_fwd (
        .clk_i(clk),
        .rst_i(rst),
        .sw_i (sw0),
        .ev_o (ev0)
    );

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_bwd (
        .clk_i(clk),
        .rst_i(rst),
        .sw_i (sw1),
        .ev_o (ev1)
    );

    assign ev_pair = {ev1, ev0};

    always_comb begin
        state_d = state_q;
        wrap_d  = wrap_q;
        pulse_d = 1'b0;
        case (ev_pair)
            EV_FWD: begin
                state_d = state_t'(state_q + 2'd1);
                if (state_q == S3) wrap_d = wrap_q + 2'd1;
                pulse_d = 1'b1;
            end
            EV_BWD: begin
                state_d = state_t'(state_q - 2'd1);
                if (state_q == S0) wrap_d = wrap_q - 2'd1;
                pulse_d = 1'b1;
            end
            EV_CLR: begin
                state_d = S0;
                wrap_d  = 2'd0;
                pulse_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            wrap_q  <= 2'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            pulse_q <= pulse_d;
        end
    end

    assign nibble     = {wrap_q, state_q};
    assign state      = state_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_sw_fsm_nibble.sv
// Scoreboard bench for sw_fsm_nibble: stimulus pushes expected {nibble, edge}
// entries, a negedge monitor pops and checks one entry per step_pulse.
module tb_sw_fsm_nibble;

    localparam int unsigned DEB = 4;
    // Drive at a negedge; next posedge samples (edge 1), nibble moves on edge DEB+4
    localparam int unsigned LAT = DEB + 4;

    typedef struct {
        logic [3:0]  nib;
        int unsigned cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw0, sw1;
    logic [3:0] nibble;
    logic [1:0] state;
    logic       step_pulse;

    exp_t        sb_q[$];
    int unsigned cyc   = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    sw_fsm_nibble #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw0       (sw0),
        .sw1       (sw1),
        .nibble    (nibble),
        .state     (state),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_nibble"}, {28'd0, nibble}, 32'h0);
        check({name, "_state"}, {30'd0, state}, 32'h0);
        check({name, "_step"}, {31'd0, step_pulse}, 32'h0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && step_pulse) begin
            if (sb_q.size() == 0) begin
                check("spurious_step_pulse", {31'd0, step_pulse}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("step_nibble", {28'd0, nibble}, {28'd0, e.nib});
                check("step_state", {30'd0, state}, {30'd0, e.nib[1:0]});
                check("step_latency", cyc, e.cyc);
            end
        end
    end

    // One press (or simultaneous pair): hold 12 cycles, release, settle low
    task automatic press(input logic f, input logic b, input logic [3:0] exp_nib);
        exp_t e;
        @(negedge clk);
        sw0   = f;
        sw1   = b;
        e.nib = exp_nib;
        e.cyc = cyc + LAT;
        sb_q.push_back(e);
        repeat (12) @(negedge clk);
        sw0 = 1'b0;
        sw1 = 1'b0;
        repeat (12) @(negedge clk);
        check("event_seen", sb_q.size(), 32'h0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        sw0 = 1'b0;
        sw1 = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single clean press with exact latency, no event on release
        press(1'b1, 1'b0, 4'h1);

        // Mid-cycle asynchronous reset clears immediately
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_zero("post_reset");

        // Bouncy input never stable for DEB cycles
        repeat (10) begin
            sw0 = 1'b1;
            repeat (3) @(negedge clk);
            sw0 = 1'b0;
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("glitch_nibble", {28'd0, nibble}, 32'h0);

        // Forward steps, backward step, backward wrap from 0
        press(1'b1, 1'b0, 4'h1);
        press(1'b1, 1'b0, 4'h2);
        press(1'b1, 1'b0, 4'h3);
        press(1'b1, 1'b0, 4'h4);
        press(1'b0, 1'b1, 4'h3);
        do_reset();
        press(1'b0, 1'b1, 4'hF);

        // Reach 0x6, clear with both switches, then full forward wrap
        do_reset();
        for (int i = 1; i <= 6; i++) press(1'b1, 1'b0, 4'(i));
        press(1'b1, 1'b1, 4'h0);
        for (int i = 1; i <= 16; i++) press(1'b1, 1'b0, 4'(i));

        // Reset mid-debounce with the switch held through release
        do_reset();
        @(negedge clk);
        sw0 = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("mid_debounce_reset");
        @(negedge clk);
        @(negedge clk);
        check_zero("held_in_reset");
        rst   = 1'b0;
        e.nib = 4'h1;
        e.cyc = cyc + LAT;
        sb_q.push_back(e);
        repeat (16) @(negedge clk);
        sw0 = 1'b0;
        repeat (12) @(negedge clk);
        check("held_event_seen", sb_q.size(), 32'h0);
        check("held_final_nibble", {28'd0, nibble}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_fsm_nibble.md
Name: sw_fsm_nibble

Overview:
- Sequential source stage that drives the 4-bit nibble into the team's hex-to-seven-segment decoder.
- Two raw board switches are synchronised and debounced, then converted to single-cycle press events.
- The press events step a 4-state machine and a 2-bit wrap counter.
- Output is {wrap_cnt, state}, so the display walks 0x0..0xF.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new switch level. Minimum 2; benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- sw0  in  1  raw switch, "forward". Asynchronous and bouncy.
- sw1  in  1  raw switch, "backward". Asynchronous and bouncy.
- nibble  out  4  {wrap_cnt[1:0], state[1:0]}. Bit 3 drives decoder w, bit 0 drives z.
- state  out  2  current FSM state code.
- step_pulse  out  1  one-cycle strobe, high in the cycle nibble takes a value produced by an event.

Behaviour:
- Reset (async assert; release is synchronised externally):
  - nibble=0, state=S0, step_pulse=0.
  - Sync flops, debounced levels, counters and edge registers all 0.
  - Takes effect immediately, mid-debounce included; a partially counted press is discarded.
- Synchroniser: 2 flops per switch. sync2 follows the pin 2 edges after the pin is sampled.
- Debounce, per switch:
  - cnt counts consecutive cycles with sync2 != deb.
  - Any cycle with sync2 == deb clears cnt.
  - When sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb toggles and cnt clears in the same edge.
- Edge detect: ev = deb & ~deb_d, registered. Falling edges generate nothing.
- Latency: a clean level change on the pin updates nibble exactly DEBOUNCE_CYCLES+4 edges after the first sampling edge. Bench checks exact latency.
- FSM states: S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.
- Per-cycle transitions (ev0, ev1):
  - 0,0: hold everything. step_pulse=0.
  - 1,0: state+1 mod 4. On S3->S0, wrap_cnt+1 mod 4.
  - 0,1: state-1 mod 4. On S0->S3, wrap_cnt-1 mod 4.
  - 1,1: state=S0 and wrap_cnt=0 (clear).
  - Any non-zero event: step_pulse=1 for that single cycle, even if the value is unchanged (e.g. clear at 0x0).
- Net arithmetic: nibble is a mod-16 up/down counter.
  - 0xF + forward -> 0x0.
  - 0x0 + backward -> 0xF.
- All outputs are registered; no combinational path from sw* to any output.
- A switch held high across reset release is a press: after the debounce latency it produces an event.
- Holding a switch high produces exactly one event. The next event requires release, debounced low, then a new press.

Decomposition:
- Shared package sw_fsm_pkg holds:
  - State encodings S0..S3 and the state_t 2-bit type.
  - Event-pair decode constants: EV_NONE, EV_FWD, EV_BWD, EV_CLR.
- One sub-module: switch_debounce.
  - Contains the synchroniser, debounce counter and rising-edge event register.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated twice.
- Top level holds the FSM, wrap counter and output registers.

Test Plan (DEBOUNCE_CYCLES=4):
1. Assert rst mid-stream for 1 cycle, asynchronous to clk -> nibble=0x0, state=0, step_pulse=0 immediately; all stay 0 with switches low.
2. sw0 high for 12 cycles then low -> nibble=0x1 and state=1 exactly 8 edges after the first sampling edge; step_pulse high exactly one cycle; no second event on release.
3. sw0 toggling with 3-cycle high / 1-cycle low periods for 40 cycles, then low -> no event, nibble stays 0x0, step_pulse never high.
4. From reset, 4 clean sw0 presses -> nibble 0x1, 0x2, 0x3, 0x4 (state=0). Then one sw1 press -> 0x3. From a fresh reset, one sw1 press -> 0xF.
5. Reach 0x6, then drive sw0 and sw1 high on the same cycle -> single event cycle, nibble=0x0, step_pulse=1 once. Drive 16 sw0 presses -> wraps to 0x0 after 0xF.
6. sw0 high, assert rst at debounce cnt=2, release rst with sw0 still high -> outputs 0 during reset; exactly one event afterwards, nibble=0x1 at DEBOUNCE_CYCLES+4 edges after release.
